seq_detector_param: RTL and testbench

Parametrised serial sequence detector; the next generation of the fixed 1010 Mealy detector. It watches a qualified serial bit stream for an N-bit pattern set at elaboration. Overlap vs non-overlap and Mealy vs Moore output are selectable at run time. A saturating match counter is included. It sits between the debounced button/serial input path and the LED/status logic.

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/seq_match_counter.sv | 38 +++
 rtl/seq_detector_param.sv | 76 +++++++
 tb/tb_seq_detector_param.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and saturating helper for the sequence detector
package seq_det_pkg;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

    function automatic longint unsigned sat_inc(input longint unsigned value,
                                                input longint unsigned limit);
        return (value >= limit) ? limit : value + 64'd1;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter with synchronous clear
module seq_match_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_inc) begin
            cnt_d = CNT_W'(sat_inc(64'(cnt_q), CNT_MAX));
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;

endmodule

// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - parametrised serial pattern detector, Mealy/Moore and overlap selectable
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_overlap,
    input  logic             i_moore,
    input  logic             i_clear,
    output logic             o_match,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned        FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0]  FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0]  FILL_THR = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              mreg_q, mreg_d;
    logic [PAT_W-1:0]  cand;
    logic              hit;

    // Fill gating keeps the reset-value zeros in hist from ever forming a match.
    assign cand = {hist_q[PAT_W-2:0], i_bit};
    assign hit  = i_valid && (fill_q >= FILL_THR) && (cand == PATTERN);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        mreg_d = hit;
        if (i_clear) begin
            hist_d = '0;
            fill_d = '0;
            mreg_d = 1'b0;
        end else if (i_valid) begin
            hist_d = cand;
            if (hit && !i_overlap) begin
                fill_d = '0;
            end else begin
                fill_d = FILL_W'(sat_inc(64'(fill_q), 64'(FILL_MAX)));
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            hist_q <= '0;
            fill_q <= '0;
            mreg_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            mreg_q <= mreg_d;
        end
    end

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_inc   (hit && !i_clear),
        .i_clear (i_clear),
        .o_count (o_count)
    );

    assign o_match = i_moore ? mreg_q : hit;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param across three configurations
module tb_seq_detector_param;

    localparam int NK = 3;

    typedef struct packed {
        logic [1:0] k;
        logic       match;
        logic [7:0] count;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, valid, bitv, ov, moore, clr;
    logic m0, m1, m2;
    logic [7:0] c0, c1;
    logic [1:0] c2;

    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(8)) u_a (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_bit(bitv), .i_overlap(ov),
        .i_moore(moore), .i_clear(clr), .o_match(m0), .o_count(c0));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b0000), .CNT_W(8)) u_b (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_bit(bitv), .i_overlap(ov),
        .i_moore(moore), .i_clear(clr), .o_match(m1), .o_count(c1));
    seq_detector_param #(.PAT_W(4), .PATTERN(4'b1010), .CNT_W(2)) u_c (
        .i_clock(clk), .i_reset(rst), .i_valid(valid), .i_bit(bitv), .i_overlap(ov),
        .i_moore(moore), .i_clear(clr), .o_match(m2), .o_count(c2));

    logic [3:0] pat  [NK] = '{4'b1010, 4'b0000, 4'b1010};
    int         cmax [NK] = '{255, 255, 3};
    logic [3:0] m_hist [NK];
    int         m_fill [NK];
    logic       m_mreg [NK];
    int         m_cnt  [NK];

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cur_bit = 0;
    int          watch = 0;
    logic [15:0] obs_mask = '0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic mhit(input int k);
        return valid && (m_fill[k] >= 3) && ({m_hist[k][2:0], bitv} == pat[k]);
    endfunction

    task automatic model_zero();
        for (int k = 0; k < NK; k++) begin
            m_hist[k] = '0; m_fill[k] = 0; m_mreg[k] = 1'b0; m_cnt[k] = 0;
        end
    endtask

    // One clock: expectations pushed at the sampling point, compared, then the model steps.
    task automatic cyc();
        logic h [NK];
        logic om [NK];
        logic [7:0] oc [NK];
        logic wm;
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            h[k]    = mhit(k);
            e.k     = 2'(k);
            e.match = moore ? m_mreg[k] : h[k];
            e.count = 8'(m_cnt[k]);
            sb.push_back(e);
        end
        om = '{m0, m1, m2};
        oc = '{c0, c1, {6'b0, c2}};
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check($sformatf("match_dut%0d", e.k), {15'b0, om[e.k]}, {15'b0, e.match});
            check($sformatf("count_dut%0d", e.k), {8'b0, oc[e.k]}, {8'b0, e.count});
        end
        wm = (watch == 0) ? m0 : ((watch == 1) ? m1 : m2);
        if (wm && cur_bit >= 1 && cur_bit <= 16) obs_mask[cur_bit-1] = 1'b1;
        for (int k = 0; k < NK; k++) begin
            if (clr) begin
                m_hist[k] = '0; m_fill[k] = 0; m_mreg[k] = 1'b0; m_cnt[k] = 0;
            end else begin
                m_mreg[k] = h[k];
                if (valid) begin
                    m_hist[k] = {m_hist[k][2:0], bitv};
                    if (h[k] && !ov) m_fill[k] = 0;
                    else if (m_fill[k] < 4) m_fill[k] = m_fill[k] + 1;
                end
                if (h[k] && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        valid = 1'b1; bitv = b; cur_bit++;
        cyc();
        valid = 1'b0; bitv = 1'b0;
        cyc();
    endtask

    task automatic send_stream(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) send_bit(bits[n-1-i]);
    endtask

    task automatic do_clear();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cur_bit = 0;
        obs_mask = '0;
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; bitv = 1'b0; ov = 1'b1; moore = 1'b0; clr = 1'b0;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        cyc();
        moore = 1'b1;
        cyc();
        moore = 1'b0;
        rst = 1'b0;

        do_clear();
        send_stream(16'b1010_1001_0101, 12);
        check("overlap_mask", obs_mask, 16'h0428);
        check("overlap_count", {8'b0, c0}, 16'd3);

        do_clear();
        ov = 1'b0;
        send_stream(16'b1010_1001_0101, 12);
        check("nonoverlap_mask", obs_mask, 16'h0408);
        check("nonoverlap_count", {8'b0, c0}, 16'd2);

        do_clear();
        ov = 1'b1; moore = 1'b1;
        send_stream(16'b1010_1001_0101, 12);
        check("moore_mask", obs_mask, 16'h0428);
        check("moore_count", {8'b0, c0}, 16'd3);

        rst = 1'b1; moore = 1'b0;
        model_zero();
        cyc();
        rst = 1'b0;
        watch = 1; cur_bit = 0; obs_mask = '0;
        send_stream(16'b000, 3);
        check("zeros3_mask", obs_mask, 16'h0000);
        check("zeros3_count", {8'b0, c1}, 16'd0);
        send_bit(1'b0);
        check("zeros4_mask", obs_mask, 16'h0008);
        send_stream(16'b00, 2);
        check("zeros6_count", {8'b0, c1}, 16'd3);

        watch = 0;
        do_clear();
        send_stream(16'b1010_1010_1010, 12);
        check("five_count", {8'b0, c0}, 16'd5);
        check("sat_count", {14'b0, c2}, 16'd3);

        moore = 1'b1;
        do_clear();
        send_stream(16'b101, 3);
        valid = 1'b1; bitv = 1'b0; clr = 1'b1;
        cyc();
        valid = 1'b0; clr = 1'b0;
        #2;
        check("clrhit_count", {8'b0, c0}, 16'd0);
        check("clrhit_moore", {15'b0, m0}, 16'd0);
        check("clrhit_sat_count", {14'b0, c2}, 16'd0);
        cyc();

        moore = 1'b0;
        send_stream(16'b1010_101, 7);
        valid = 1'b1; bitv = 1'b0;
        #1;
        check("prereset_hit", {15'b0, m0}, 16'd1);
        rst = 1'b1;
        #1;
        check("async_match", {15'b0, m0}, 16'd0);
        check("async_count", {8'b0, c0}, 16'd0);
        valid = 1'b0; bitv = 1'b0;
        model_zero();
        cyc();
        rst = 1'b0;
        cur_bit = 0; obs_mask = '0;
        send_stream(16'b01010, 5);
        check("postreset_mask", obs_mask, 16'h0010);
        check("postreset_count", {8'b0, c0}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
